vec_xbar: RTL
=============

VEC_XBAR -- requirements
Module: vec_xbar

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 20, number of source element streams.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 4, number of independent output channels.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, element data width.
REQ-004 SHALL have parameter VALID, default 1, valid-bit width; valid bit sits at position DATA_WIDTH of each element.
REQ-005 SHALL have parameter MVL, default 32, maximum vector length.
REQ-006 SHALL define SW = bitwidth(NUM_INPUTS), CW = bitwidth(MVL)+1, EW = DATA_WIDTH+VALID.
REQ-007 SHALL have port clk  in  1  the only clock.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port start  in  NUM_OUTPUTS  per-channel start request.
REQ-010 SHALL have port sel  in  NUM_OUTPUTS*SW  packed per-channel source select, channel p at [SW*(p+1)-1:SW*p].
REQ-011 SHALL have port VLR  in  NUM_OUTPUTS*CW  packed per-channel vector length.
REQ-012 SHALL have port data_i  in  NUM_INPUTS*EW  packed source elements, input i at [EW*(i+1)-1:EW*i].
REQ-013 SHALL have port in_ready  out  NUM_INPUTS  per-source consume strobe.
REQ-014 SHALL have port out_ready  in  NUM_OUTPUTS  per-channel sink ready.
REQ-015 SHALL have port data_o  out  NUM_OUTPUTS*EW  packed per-channel elements.
REQ-016 SHALL have ports busy_o and done_o  out  NUM_OUTPUTS  channel running / one-cycle completion pulse.

Function
REQ-017 Each channel SHALL run a two-state FSM IDLE/RUN with registers sel_reg, vlr_reg, cnt (CW bits).
REQ-018 IDLE: start[p]=1, sel[p]<NUM_INPUTS, VLR[p]!=0 -> RUN next edge; sel_reg<=sel, vlr_reg<=min(VLR,MVL), cnt<=0.
REQ-019 IDLE: start with VLR=0 -> stay IDLE, done_o[p]=1 next cycle; start with sel>=NUM_INPUTS -> ignored, no done.
REQ-020 start[p] in RUN SHALL be ignored (no queueing).
REQ-021 data_o[p] SHALL equal inputs[sel_reg] combinationally in RUN, all zeros in IDLE.
REQ-022 in_ready[i] SHALL be AND of out_ready[p] over channels in RUN with sel_reg==i; 1 when no channel selects i.
REQ-023 Transfer on channel p SHALL occur when RUN & inputs[sel_reg][DATA_WIDTH] & in_ready[sel_reg]; multicast sharers advance in lockstep.
REQ-024 Each transfer SHALL increment cnt; transfer with cnt==vlr_reg-1 -> IDLE next edge, registers zeroed, done_o[p]=1 for exactly that next cycle.
REQ-025 Valid low or stalled SHALL hold cnt; no element dropped or duplicated.
REQ-026 busy_o[p] SHALL equal state==RUN.
REQ-027 Channels SHALL be independent; simultaneous starts on all channels SHALL all be accepted.

Reset
REQ-028 rst SHALL asynchronously force all channels IDLE, cnt/sel_reg/vlr_reg=0, busy_o=0, done_o=0, data_o=0, in_ready=all ones, including mid-vector; no done pulse for aborted vectors.

Configuration
REQ-029 With VEC_XBAR_ERR_EN defined, SHALL add err_o (out, NUM_OUTPUTS, sticky) and err_clr (in, NUM_OUTPUTS); err_o[p] set on start in RUN or sel>=NUM_INPUTS, cleared by err_clr[p] or rst; set wins over clear same cycle.
REQ-030 Without VEC_XBAR_ERR_EN, err_o/err_clr SHALL not exist; functional behaviour otherwise identical.

Structure
REQ-031 log2/bitwidth functions and FSM state encodings SHALL live in shared package vec_pkg.
REQ-032 Per-channel FSM/counter SHALL be sub-module vec_xbar_chan, instantiated NUM_OUTPUTS times by generate; in_ready reduction in top level.

Verification
REQ-033 ch0 start sel=3 VLR=4, input3 valid every cycle, out_ready=1 -> 4 transfers, busy 4 cycles, done_o[0] pulse cycle 5.
REQ-034 ch0 and ch1 sel=5 VLR=3, out_ready[1] low 2 cycles -> in_ready[5] low 2 cycles, both cnt frozen, both done same cycle.
REQ-035 start VLR=0 -> no busy, done pulse next cycle; VLR=40 with MVL=32 -> exactly 32 transfers.
REQ-036 rst asserted after 2 of 8 transfers -> immediate IDLE, data_o=0, no done; restart completes 8.
REQ-037 sel=25 with NUM_INPUTS=20 -> ignored; with VEC_XBAR_ERR_EN err_o=1 until err_clr.
REQ-038 input valid toggling 1/0 with VLR=6 -> done after 12 cycles, data_o sequence matches valid elements in order.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared helpers and channel state encoding for the vector crossbar.
package vec_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } chan_state_e;

    function automatic int unsigned log2(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Bits needed to hold the value n itself.
    function automatic int unsigned bitwidth(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vec_xbar_chan.sv
// One crossbar output channel: IDLE/RUN FSM with element counter.
// With VEC_XBAR_ERR_EN defined, adds a sticky protocol-error flag.
module vec_xbar_chan import vec_pkg::*; #(
    parameter int unsigned NUM_INPUTS = 20,
    parameter int unsigned MVL        = 32,
    parameter int unsigned SW         = bitwidth(NUM_INPUTS),
    parameter int unsigned CW         = bitwidth(MVL) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] sel_i,
    input  logic [CW-1:0] vlr_i,
    input  logic          xfer_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [SW-1:0] sel_o
`ifdef VEC_XBAR_ERR_EN
    ,
    input  logic          err_clr_i,
    output logic          err_o
`endif
);

    chan_state_e   state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [CW-1:0] vlr_q, vlr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          sel_ok;

    assign sel_ok = (sel_i < SW'(NUM_INPUTS));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vlr_d   = vlr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && sel_ok) begin
                    if (vlr_i == '0) begin
                        // Empty vector completes immediately without running.
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        sel_d   = sel_i;
                        vlr_d   = (vlr_i > CW'(MVL)) ? CW'(MVL) : vlr_i;
                        cnt_d   = '0;
                    end
                end
            end
            StRun: begin
                if (xfer_i) begin
                    if (cnt_q + CW'(1) == vlr_q) begin
                        state_d = StIdle;
                        sel_d   = '0;
                        vlr_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            vlr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vlr_q   <= vlr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = done_q;
    assign sel_o  = sel_q;

`ifdef VEC_XBAR_ERR_EN
    logic err_q, err_d;
    logic err_set;

    // Set has priority over a same-cycle clear.
    assign err_set = start_i && ((state_q == StRun) || !sel_ok);
    assign err_d   = err_set || (err_q && !err_clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: rtl/vec_xbar.sv
// Vector crossbar: NUM_OUTPUTS channels each stream VLR elements from a chosen source.
// Optional sticky error flags when VEC_XBAR_ERR_EN is defined.
module vec_xbar import vec_pkg::*; #(
    parameter int unsigned NUM_INPUTS  = 20,
    parameter int unsigned NUM_OUTPUTS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned VALID       = 1,
    parameter int unsigned MVL         = 32,
    localparam int unsigned SW         = bitwidth(NUM_INPUTS),
    localparam int unsigned CW         = bitwidth(MVL) + 1,
    localparam int unsigned EW         = DATA_WIDTH + VALID
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_OUTPUTS-1:0]      start,
    input  logic [NUM_OUTPUTS*SW-1:0]   sel,
    input  logic [NUM_OUTPUTS*CW-1:0]   VLR,
    input  logic [NUM_INPUTS*EW-1:0]    data_i,
    output logic [NUM_INPUTS-1:0]       in_ready,
    input  logic [NUM_OUTPUTS-1:0]      out_ready,
    output logic [NUM_OUTPUTS*EW-1:0]   data_o,
    output logic [NUM_OUTPUTS-1:0]      busy_o,
    output logic [NUM_OUTPUTS-1:0]      done_o
`ifdef VEC_XBAR_ERR_EN
    ,
    output logic [NUM_OUTPUTS-1:0]      err_o,
    input  logic [NUM_OUTPUTS-1:0]      err_clr
`endif
);

    logic [SW-1:0]          chan_sel [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] chan_busy;
    logic [NUM_OUTPUTS-1:0] xfer;

    for (genvar p = 0; p < NUM_OUTPUTS; p++) begin : g_chan
        vec_xbar_chan #(
            .NUM_INPUTS (NUM_INPUTS),
            .MVL        (MVL),
            .SW         (SW),
            .CW         (CW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .start_i    (start[p]),
            .sel_i      (sel[SW*p +: SW]),
            .vlr_i      (VLR[CW*p +: CW]),
            .xfer_i     (xfer[p]),
            .busy_o     (chan_busy[p]),
            .done_o     (done_o[p]),
            .sel_o      (chan_sel[p])
`ifdef VEC_XBAR_ERR_EN
            ,
            .err_clr_i  (err_clr[p]),
            .err_o      (err_o[p])
`endif
        );
    end

    assign busy_o = chan_busy;

    // A source advances only when every running channel reading it can accept.
    always_comb begin
        in_ready = '1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            for (int p = 0; p < NUM_OUTPUTS; p++) begin
                if (chan_busy[p] && (chan_sel[p] == SW'(i)) && !out_ready[p]) begin
                    in_ready[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        xfer   = '0;
        for (int p = 0; p < NUM_OUTPUTS; p++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (chan_busy[p] && (chan_sel[p] == SW'(i))) begin
                    data_o[EW*p +: EW] = data_i[EW*i +: EW];
                    xfer[p]            = data_i[EW*i + DATA_WIDTH] && in_ready[i];
                end
            end
        end
    end

endmodule
